// File: rtl/sort_hw_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_hw_ctrl_pkg
// Brief    : Shared state encoding and RAM timing constant for the bubble sorter.
// Revision : 1.0
// ============================================================================
package sort_hw_ctrl_pkg;

    localparam int RD_LATENCY = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_CMP  = 3'd3,
        S_WR_A = 3'd4,
        S_WR_B = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sort_hw_cmp.sv
`default_nettype none
// ============================================================================
// Module   : sort_hw_cmp
// Brief    : Combinational greater-than, unsigned or two's-complement.
// Revision : 1.0
// ============================================================================
module sort_hw_cmp #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              signed_mode,
    output logic              gt
);

    always_comb begin
        gt = 1'b0;
        if (signed_mode) begin
            gt = ($signed(a) > $signed(b));
        end else begin
            gt = (a > b);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sort_hw_bubble_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort_hw_bubble_ctrl
// Brief    : In-place bubble sort of a RAM region over a 1-cycle-latency port.
// Revision : 1.0
// ============================================================================
module sort_hw_bubble_ctrl
    import sort_hw_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 32,
    parameter int SIGNED_CMP = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base,
    input  logic [ADDR_W:0]     length,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         swap_count,
    output logic [ADDR_W-1:0]   ram_address,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
);

    localparam logic [ADDR_W:0]   c_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_TWO   = (ADDR_W+1)'(2);
    localparam logic [ADDR_W-1:0] c_ONE_A = ADDR_W'(1);
    localparam logic [ADDR_W+1:0] c_LIMIT = (ADDR_W+2)'(1) << ADDR_W;
    localparam logic              c_SIGNED_MODE = (SIGNED_CMP != 0);
    localparam logic [31:0]       c_CNT_MAX = 32'hFFFF_FFFF;

    state_t              r_state_q, w_state_d;
    logic [ADDR_W:0]     r_i_q, w_i_d;
    logic [ADDR_W:0]     r_last_q, w_last_d;
    logic [ADDR_W:0]     r_base_q, w_base_d;
    logic                r_swapped_q, w_swapped_d;
    logic [DATA_W-1:0]   r_a_q, w_a_d;
    logic [DATA_W-1:0]   r_b_q, w_b_d;
    logic [31:0]         r_swap_cnt_q, w_swap_cnt_d;
    logic                r_done_q;
    logic                r_err_q, w_err_d;

    logic                w_gt;
    logic [ADDR_W+1:0]   w_end;
    logic [ADDR_W-1:0]   w_addr_i;
    logic [ADDR_W-1:0]   w_addr_i1;

    // One extra bit beyond the address arithmetic so base+length up to 2^(ADDR_W+1)-1 cannot wrap.
    assign w_end     = {2'b00, base} + {1'b0, length};
    assign w_addr_i  = r_i_q[ADDR_W-1:0];
    assign w_addr_i1 = w_addr_i + c_ONE_A;

    sort_hw_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a           (r_a_q),
        .b           (ram_readdata),
        .signed_mode (c_SIGNED_MODE),
        .gt          (w_gt)
    );

    always_comb begin
        w_state_d      = r_state_q;
        w_i_d          = r_i_q;
        w_last_d       = r_last_q;
        w_base_d       = r_base_q;
        w_swapped_d    = r_swapped_q;
        w_a_d          = r_a_q;
        w_b_d          = r_b_q;
        w_swap_cnt_d   = r_swap_cnt_q;
        w_err_d        = 1'b0;
        ram_address    = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;

        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    if (length <= c_ONE) begin
                        w_state_d = S_DONE;
                    end else if (w_end > c_LIMIT) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_base_d     = {1'b0, base};
                        w_i_d        = {1'b0, base};
                        w_last_d     = {1'b0, base} + length - c_TWO;
                        w_swapped_d  = 1'b0;
                        w_swap_cnt_d = '0;
                        w_state_d    = S_RD_A;
                    end
                end
            end
            S_RD_A: begin
                ram_chipselect = 1'b1;
                ram_address    = w_addr_i;
                w_state_d      = S_RD_B;
            end
            S_RD_B: begin
                ram_chipselect = 1'b1;
                ram_address    = w_addr_i1;
                w_a_d          = ram_readdata;
                w_state_d      = S_CMP;
            end
            S_CMP: begin
                // Strict greater-than keeps equal keys in place.
                w_b_d     = ram_readdata;
                w_state_d = w_gt ? S_WR_A : S_NEXT;
            end
            S_WR_A: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = w_addr_i;
                ram_writedata  = r_b_q;
                w_state_d      = S_WR_B;
            end
            S_WR_B: begin
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_address    = w_addr_i1;
                ram_writedata  = r_a_q;
                w_swapped_d    = 1'b1;
                if (r_swap_cnt_q != c_CNT_MAX) begin
                    w_swap_cnt_d = r_swap_cnt_q + 32'd1;
                end
                w_state_d = S_NEXT;
            end
            S_NEXT: begin
                if (r_i_q < r_last_q) begin
                    w_i_d     = r_i_q + c_ONE;
                    w_state_d = S_RD_A;
                end else if (!r_swapped_q || (r_last_q == r_base_q)) begin
                    w_state_d = S_DONE;
                end else begin
                    w_last_d    = r_last_q - c_ONE;
                    w_i_d       = r_base_q;
                    w_swapped_d = 1'b0;
                    w_state_d   = S_RD_A;
                end
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state_q    <= S_IDLE;
            r_i_q        <= '0;
            r_last_q     <= '0;
            r_base_q     <= '0;
            r_swapped_q  <= 1'b0;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_swap_cnt_q <= '0;
            r_done_q     <= 1'b0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_i_q        <= w_i_d;
            r_last_q     <= w_last_d;
            r_base_q     <= w_base_d;
            r_swapped_q  <= w_swapped_d;
            r_a_q        <= w_a_d;
            r_b_q        <= w_b_d;
            r_swap_cnt_q <= w_swap_cnt_d;
            r_done_q     <= (r_state_q == S_DONE);
            r_err_q      <= w_err_d;
        end
    end

    assign busy           = (r_state_q != S_IDLE);
    assign done           = r_done_q;
    assign err            = r_err_q;
    assign swap_count     = r_swap_cnt_q;
    assign ram_byteenable = '1;
    assign ram_clken      = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_sort_hw_bubble_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_hw_bubble_ctrl
// Brief    : Bench with an unsigned and a signed instance sharing stimulus.
// Revision : 1.0
// ============================================================================
module tb_sort_hw_bubble_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [10:0] base = '0;
    logic [11:0] length = '0;

    logic [1:0]  busy_s, done_s, err_s, cs_s, wr_s, clken_s;
    logic [31:0] swc [2];
    logic [10:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  be [2];
    logic [31:0] rdata [2];

    logic [31:0] mem [2][2048];
    logic        tb_we = 1'b0;
    logic [10:0] tb_addr = '0;
    logic [31:0] tb_wdata = '0;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    int bfrom [2] = '{1, 1};
    int bto   [2] = '{0, 0};
    int dat   [2] = '{-1, -1};
    int eat   [2] = '{-1, -1};
    bit acc   [2] = '{1'b0, 1'b0};

    logic [31:0] exp_mem [2][64];
    int exp_swaps [2] = '{0, 0};
    int lat [2] = '{0, 0};
    int exp_b = 0;
    int exp_n = 0;
    bit exp_sorted = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sort_hw_bubble_ctrl #(.ADDR_W(11), .DATA_W(32), .SIGNED_CMP(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .base(base), .length(length),
        .busy(busy_s[0]), .done(done_s[0]), .err(err_s[0]), .swap_count(swc[0]),
        .ram_address(addr[0]), .ram_chipselect(cs_s[0]), .ram_write(wr_s[0]),
        .ram_writedata(wdata[0]), .ram_byteenable(be[0]), .ram_clken(clken_s[0]),
        .ram_readdata(rdata[0])
    );

    sort_hw_bubble_ctrl #(.ADDR_W(11), .DATA_W(32), .SIGNED_CMP(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .base(base), .length(length),
        .busy(busy_s[1]), .done(done_s[1]), .err(err_s[1]), .swap_count(swc[1]),
        .ram_address(addr[1]), .ram_chipselect(cs_s[1]), .ram_write(wr_s[1]),
        .ram_writedata(wdata[1]), .ram_byteenable(be[1]), .ram_clken(clken_s[1]),
        .ram_readdata(rdata[1])
    );

    // Synchronous RAM with one cycle of read latency, plus a bench-side load port.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (tb_we) mem[k][tb_addr] <= tb_wdata;
            else if (cs_s[k] && wr_s[k]) mem[k][addr[k]] <= wdata[k];
            rdata[k] <= mem[k][addr[k]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit gtf(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        if (sgn) return $signed(a) > $signed(b);
        return a > b;
    endfunction

    // Plain bubble sort of the region: final contents, swap total and start-to-done latency.
    task automatic model(input int k, input int b, input int n,
                         output int l, output int sw, output logic [31:0] q[$]);
        int last;
        bit swd;
        logic [31:0] tmp;
        q = {};
        for (int j = 0; j < n; j++) q.push_back(mem[k][b + j]);
        l = 2;
        sw = 0;
        last = n - 2;
        do begin
            swd = 1'b0;
            for (int j = 0; j <= last; j++) begin
                l += 4;
                if (gtf(k == 1, q[j], q[j + 1])) begin
                    tmp = q[j]; q[j] = q[j + 1]; q[j + 1] = tmp;
                    l += 2; sw++; swd = 1'b1;
                end
            end
            last--;
        end while (swd && last >= 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                bit eb;
                eb = (cyc >= bfrom[k]) && (cyc <= bto[k]);
                chk($sformatf("busy%0d", k), 64'(busy_s[k]), 64'(eb));
                chk($sformatf("done%0d", k), 64'(done_s[k]), 64'(cyc == dat[k]));
                chk($sformatf("err%0d", k), 64'(err_s[k]), 64'(cyc == eat[k]));
                if (!eb || !acc[k]) chk($sformatf("cs_quiet%0d", k), 64'(cs_s[k]), 64'd0);
            end
        end
    end

    task automatic load(input int b, input logic [31:0] v[$]);
        foreach (v[j]) begin
            @(negedge clk); #2;
            tb_we = 1'b1; tb_addr = 11'(b + j); tb_wdata = v[j];
        end
        @(negedge clk); #2;
        tb_we = 1'b0;
    endtask

    task automatic run(input int b, input int n);
        int t0, l, sw;
        logic [31:0] q[$];
        exp_b = b; exp_n = n; exp_sorted = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (n <= 1) begin
                lat[k] = 2; acc[k] = 1'b0;
            end else if (b + n > 2048) begin
                lat[k] = -1; acc[k] = 1'b0;
            end else begin
                model(k, b, n, l, sw, q);
                lat[k] = l; exp_swaps[k] = sw; acc[k] = 1'b1; exp_sorted = 1'b1;
                foreach (q[j]) exp_mem[k][j] = q[j];
            end
        end
        @(negedge clk); #2;
        start = 1'b1; base = 11'(b); length = 12'(n);
        t0 = cyc;
        for (int k = 0; k < 2; k++) begin
            if (lat[k] < 0) begin
                bfrom[k] = 1; bto[k] = 0; dat[k] = -1; eat[k] = t0 + 1;
            end else begin
                bfrom[k] = t0 + 1; bto[k] = t0 + lat[k] - 1; dat[k] = t0 + lat[k]; eat[k] = -1;
            end
        end
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic finish_run();
        int m;
        m = (lat[0] > lat[1]) ? lat[0] : lat[1];
        if (m < 2) m = 2;
        repeat (m + 2) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (exp_sorted)
                for (int j = 0; j < exp_n; j++)
                    chk($sformatf("ram%0d[%0d]", k, exp_b + j), 64'(mem[k][exp_b + j]), 64'(exp_mem[k][j]));
            chk($sformatf("swap_count%0d", k), 64'(swc[k]), 64'(exp_swaps[k]));
        end
    endtask

    task automatic chk_reset_state(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), 64'(busy_s[k]), 64'd0);
            chk($sformatf("%s_done%0d", tag, k), 64'(done_s[k]), 64'd0);
            chk($sformatf("%s_err%0d", tag, k), 64'(err_s[k]), 64'd0);
            chk($sformatf("%s_swc%0d", tag, k), 64'(swc[k]), 64'd0);
            chk($sformatf("%s_cs%0d", tag, k), 64'(cs_s[k]), 64'd0);
            chk($sformatf("%s_wr%0d", tag, k), 64'(wr_s[k]), 64'd0);
            chk($sformatf("%s_addr%0d", tag, k), 64'(addr[k]), 64'd0);
            chk($sformatf("%s_wdata%0d", tag, k), 64'(wdata[k]), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        #3;
        chk_reset_state("reset");
        chk("byteenable", 64'(be[0]), 64'hF);
        chk("clken", 64'(clken_s[1]), 64'd1);
        repeat (2) @(negedge clk);
        #2;
        reset_n = 1'b1;
        chk_en = 1'b1;

        // Reverse order: six swaps, fully sorted.
        load(0, '{32'd4, 32'd3, 32'd2, 32'd1});
        run(0, 4);
        finish_run();
        chk("t1_w0", 64'(mem[0][0]), 64'd1);
        chk("t1_w3", 64'(mem[0][3]), 64'd4);
        chk("t1_swaps", 64'(swc[0]), 64'd6);

        // Region ending at the top word, already ascending: single pass, done at +30.
        load(2040, '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17});
        run(2040, 8);
        chk("t2_model_lat", 64'(lat[0]), 64'd30);
        finish_run();
        chk("t2_swaps", 64'(swc[0]), 64'd0);

        // Region running past the end of RAM.
        run(2047, 2);
        finish_run();

        // Signed versus unsigned ordering.
        load(100, '{32'h0000_0001, 32'hFFFF_FFFF});
        run(100, 2);
        finish_run();
        chk("t4_uns_w0", 64'(mem[0][100]), 64'h1);
        chk("t4_sgn_w0", 64'(mem[1][100]), 64'hFFFF_FFFF);
        chk("t4_sgn_w1", 64'(mem[1][101]), 64'h1);

        // Trivial lengths.
        run(5, 1);
        chk("t5_model_lat", 64'(lat[0]), 64'd2);
        finish_run();
        run(0, 0);
        finish_run();

        // Mixed data with duplicates; a second start mid-sort must be ignored.
        load(200, '{32'd5, 32'hFFFF_FFFE, 32'd5, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd3, 32'd3,
                    32'd1, 32'hFFFF_FFFF, 32'd9, 32'd2, 32'd0, 32'd5, 32'd10, 32'd4});
        run(200, 16);
        repeat (3) @(negedge clk);
        #2;
        start = 1'b1; base = 11'd0; length = 12'd3;
        @(negedge clk); #2;
        start = 1'b0;
        finish_run();

        // Asynchronous reset in the middle of the first write.
        load(300, '{32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        run(300, 6);
        n = 0;
        while (!wr_s[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t8_write_seen", 64'(n < 100), 64'd1);
        #2;
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bfrom[k] = 1; bto[k] = 0; dat[k] = -1; eat[k] = -1; exp_swaps[k] = 0;
        end
        #1;
        chk_reset_state("midreset");
        @(negedge clk); #2;
        reset_n = 1'b1;
        run(300, 6);
        finish_run();
        chk("t8_w0", 64'(mem[0][300]), 64'd1);
        chk("t8_w5", 64'(mem[0][305]), 64'd6);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sort_hw_bubble_ctrl.md
SORT_HW_BUBBLE_CTRL -- requirements
Module: sort_hw_bubble_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 11: word-address width of the data RAM (2048 words).
REQ-002 SHALL have parameter DATA_W, default 32: key width.
REQ-003 SHALL have parameter SIGNED_CMP, default 0: 1 = two's-complement compare, 0 = unsigned.
REQ-004 SHALL use one clock and asynchronous, active-low reset: clk and reset_n.
REQ-005 SHALL have port clk, input, 1: sole clock.
REQ-006 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle sort request, sampled only in IDLE.
REQ-008 SHALL have port base, input, ADDR_W: first word address, sampled with start.
REQ-009 SHALL have port length, input, ADDR_W+1: word count (0..2048), sampled with start.
REQ-010 SHALL have port busy, output, 1: high from the cycle after accepted start until DONE exits.
REQ-011 SHALL have port done, output, 1: one-cycle pulse on completion.
REQ-012 SHALL have port err, output, 1: one-cycle pulse when base+length > 2^ADDR_W.
REQ-013 SHALL have port swap_count, output, 32: swaps in the current/last sort, saturating.
REQ-014 SHALL have port ram_address, output, ADDR_W: RAM word address.
REQ-015 SHALL have port ram_chipselect, output, 1: RAM select, high on every read or write cycle.
REQ-016 SHALL have port ram_write, output, 1: write strobe.
REQ-017 SHALL have port ram_writedata, output, DATA_W: write data.
REQ-018 SHALL have port ram_byteenable, output, DATA_W/8: constant all-ones.
REQ-019 SHALL have port ram_clken, output, 1: constant 1.
REQ-020 SHALL have port ram_readdata, input, DATA_W: data for the address presented one cycle earlier (fixed 1-cycle read latency).

Function
REQ-021 SHALL implement states IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE.
REQ-022 In IDLE with start: length<=1 SHALL go to DONE; range error SHALL pulse err next cycle and stay IDLE with no RAM access; otherwise i=base, last=base+length-2, swapped=0, swap_count=0, go to RD_A.
REQ-023 RD_A SHALL drive ram_address=i, chipselect=1, write=0.
REQ-024 RD_B SHALL drive ram_address=i+1 and capture ram_readdata into reg A.
REQ-025 CMP SHALL capture ram_readdata into reg B, with no RAM access; A>B per SIGNED_CMP goes to WR_A, otherwise NEXT.
REQ-026 WR_A SHALL write B at i.
REQ-027 WR_B SHALL write A at i+1, set swapped, and increment swap_count (saturating at 0xFFFFFFFF).
REQ-028 NEXT with i<last SHALL do i++ and go to RD_A.
REQ-029 NEXT with i==last SHALL go to DONE if swapped==0 or last==base; else last--, i=base, swapped=0, go to RD_A.
REQ-030 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-031 Equal keys SHALL never be swapped (stable sort).
REQ-032 start while busy SHALL be ignored.
REQ-033 Address arithmetic SHALL use ADDR_W+1 bits; a region ending exactly at word 2047 is legal.
REQ-034 Cycle cost: 4 cycles per non-swapping compare, 6 per swapping compare.

Reset
REQ-035 reset_n low SHALL asynchronously force IDLE and clear busy, done, err, swap_count, ram_chipselect, ram_write, ram_address, and ram_writedata.
REQ-036 Reset mid-sort SHALL abort immediately with no further RAM access; RAM contents are left partially sorted, and no done pulse is produced.

Structure
REQ-037 Package sort_hw_ctrl_pkg SHALL hold the state enum and the RD_LATENCY=1 constant.
REQ-038 The compare SHALL be a combinational sub-module sort_hw_cmp (a, b, signed_mode -> gt).

Verification
REQ-039 base=0, length=4, RAM {4,3,2,1} -> RAM {1,2,3,4}, swap_count=6, one done pulse.
REQ-040 base=2040, length=8, RAM already ascending -> one pass only, swap_count=0, done 4*7+2 cycles after start.
REQ-041 base=2047, length=2 -> err pulse, busy stays 0, no ram_chipselect.
REQ-042 SIGNED_CMP=1, RAM {0x00000001, 0xFFFFFFFF} -> swapped to {0xFFFFFFFF, 0x00000001}; SIGNED_CMP=0 -> unchanged.
REQ-043 length=1 -> done 2 cycles after start, no RAM access; start asserted again while busy on a length=16 sort -> ignored.
REQ-044 reset_n pulsed low during WR_A -> outputs immediately at reset values; a following start sorts correctly.
